// File: rtl/r_resp_mux_skid_pkg.sv
// Shared R-channel constants and the packed R beat payload.
package r_resp_mux_skid_pkg;

   localparam int unsigned NUM_R_SLV  = 5;
   localparam int unsigned R_SEL_NONE = 5;
   localparam int unsigned SID_W      = 6;
   localparam int unsigned DATA_W     = 32;
   localparam int unsigned RESP_W     = 2;
   localparam int unsigned CNT_W      = 16;

   typedef struct packed {
      logic [SID_W-1:0]  id;
      logic [DATA_W-1:0] data;
      logic [RESP_W-1:0] resp;
      logic              last;
   } r_beat_t;

   localparam int unsigned R_BEAT_W = $bits(r_beat_t);

   typedef enum logic {
      ST_IDLE,
      ST_BURST
   } burst_state_e;

endpackage

// File: rtl/r_skid_buffer.sv
// Generic 2-entry valid/ready register pair; out is the head, skid holds one overflow beat.
module r_skid_buffer #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         in_ready_c,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   input  logic         out_ready
);

   logic         skid_valid;
   logic [W-1:0] skid_data;

   assign in_ready_c = !skid_valid;

   // Head refills from skid first so beat order is preserved.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         skid_valid <= 1'b0;
         skid_data  <= '0;
      end else if (!out_valid || out_ready) begin
         if (skid_valid) begin
            out_valid  <= 1'b1;
            out_data   <= skid_data;
            skid_valid <= in_valid;
            if (in_valid) skid_data <= in_data;
         end else begin
            out_valid <= in_valid;
            if (in_valid) out_data <= in_data;
         end
      end else if (in_valid) begin
         skid_valid <= 1'b1;
         skid_data  <= in_data;
      end
   end

endmodule

// File: rtl/r_resp_mux_skid.sv
// R-channel slave mux with burst lock, 2-entry output skid and completed-burst counter.
module r_resp_mux_skid
   import r_resp_mux_skid_pkg::*;
#(
   parameter int unsigned sID_width  = SID_W,
   parameter int unsigned data_width = DATA_W,
   parameter int unsigned cnt_width  = CNT_W
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [2:0]            R_slv_sel,
   input  logic                  hold,
   input  logic                  s0_RVALID,
   input  logic [sID_width-1:0]  s0_RID,
   input  logic [data_width-1:0] s0_RDATA,
   input  logic [1:0]            s0_RRESP,
   input  logic                  s0_RLAST,
   output logic                  s0_RREADY,
   input  logic                  s1_RVALID,
   input  logic [sID_width-1:0]  s1_RID,
   input  logic [data_width-1:0] s1_RDATA,
   input  logic [1:0]            s1_RRESP,
   input  logic                  s1_RLAST,
   output logic                  s1_RREADY,
   input  logic                  s2_RVALID,
   input  logic [sID_width-1:0]  s2_RID,
   input  logic [data_width-1:0] s2_RDATA,
   input  logic [1:0]            s2_RRESP,
   input  logic                  s2_RLAST,
   output logic                  s2_RREADY,
   input  logic                  s3_RVALID,
   input  logic [sID_width-1:0]  s3_RID,
   input  logic [data_width-1:0] s3_RDATA,
   input  logic [1:0]            s3_RRESP,
   input  logic                  s3_RLAST,
   output logic                  s3_RREADY,
   input  logic                  s4_RVALID,
   input  logic [sID_width-1:0]  s4_RID,
   input  logic [data_width-1:0] s4_RDATA,
   input  logic [1:0]            s4_RRESP,
   input  logic                  s4_RLAST,
   output logic                  s4_RREADY,
   output logic                  m_RVALID,
   output logic [sID_width-1:0]  m_RID,
   output logic [data_width-1:0] m_RDATA,
   output logic [1:0]            m_RRESP,
   output logic                  m_RLAST,
   input  logic                  m_RREADY,
   output logic                  beat_accept,
   output logic                  beat_last,
   output logic                  burst_active,
   output logic [cnt_width-1:0]  bursts_done
);

   burst_state_e         state, state_d;
   logic [2:0]           locked_sel, locked_sel_d;
   logic [2:0]           sel_eff;
   logic                 allow;
   logic                 in_ready;
   logic                 up_fire;
   logic [NUM_R_SLV-1:0] rvalid, rready;
   r_beat_t              beats [NUM_R_SLV];
   r_beat_t              in_beat, out_beat;

   assign rvalid   = {s4_RVALID, s3_RVALID, s2_RVALID, s1_RVALID, s0_RVALID};
   assign beats[0] = '{id: s0_RID, data: s0_RDATA, resp: s0_RRESP, last: s0_RLAST};
   assign beats[1] = '{id: s1_RID, data: s1_RDATA, resp: s1_RRESP, last: s1_RLAST};
   assign beats[2] = '{id: s2_RID, data: s2_RDATA, resp: s2_RRESP, last: s2_RLAST};
   assign beats[3] = '{id: s3_RID, data: s3_RDATA, resp: s3_RRESP, last: s3_RLAST};
   assign beats[4] = '{id: s4_RID, data: s4_RDATA, resp: s4_RRESP, last: s4_RLAST};

   assign {s4_RREADY, s3_RREADY, s2_RREADY, s1_RREADY, s0_RREADY} = rready;

   assign sel_eff = (state == ST_BURST) ? locked_sel : R_slv_sel;
   assign allow   = (state == ST_BURST) || !hold;

   // One-hot ready to the selected slave; selects at or above R_SEL_NONE never match.
   always_comb begin
      rready  = '0;
      in_beat = '0;
      up_fire = 1'b0;
      for (int i = 0; i < NUM_R_SLV; i++) begin
         if (!reset && allow && in_ready && sel_eff == 3'(i) && sel_eff < 3'(R_SEL_NONE)) begin
            rready[i] = 1'b1;
            in_beat   = beats[i];
            up_fire   = rvalid[i];
         end
      end
   end

   always_comb begin
      state_d      = state;
      locked_sel_d = locked_sel;
      case (state)
         ST_IDLE: begin
            if (up_fire && !in_beat.last) begin
               state_d      = ST_BURST;
               locked_sel_d = R_slv_sel;
            end
         end
         ST_BURST: begin
            if (up_fire && in_beat.last) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         locked_sel  <= 3'(R_SEL_NONE);
         bursts_done <= '0;
      end else begin
         state      <= state_d;
         locked_sel <= locked_sel_d;
         if (beat_last) bursts_done <= bursts_done + cnt_width'(1);
      end
   end

   r_skid_buffer #(
      .W (R_BEAT_W)
   ) u_skid (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (up_fire),
      .in_data    (in_beat),
      .in_ready_c (in_ready),
      .out_valid  (m_RVALID),
      .out_data   (out_beat),
      .out_ready  (m_RREADY)
   );

   assign m_RID   = out_beat.id;
   assign m_RDATA = out_beat.data;
   assign m_RRESP = out_beat.resp;
   assign m_RLAST = out_beat.last;

   assign beat_accept  = !reset && m_RVALID && m_RREADY;
   assign beat_last    = beat_accept && m_RLAST;
   assign burst_active = (state == ST_BURST);

endmodule

// File: tb/tb_r_resp_mux_skid.sv
// Randomized bench for r_resp_mux_skid against a queue-based transaction model.
module tb_r_resp_mux_skid;
   import r_resp_mux_skid_pkg::*;

   logic              clk = 1'b0;
   logic              reset;
   logic [2:0]        r_slv_sel;
   logic              hold;
   logic [4:0]        s_rvalid;
   logic [SID_W-1:0]  s_rid   [5];
   logic [DATA_W-1:0] s_rdata [5];
   logic [1:0]        s_rresp [5];
   logic [4:0]        s_rlast;
   logic [4:0]        s_rready;
   logic              m_rvalid, m_rlast, m_rready;
   logic [SID_W-1:0]  m_rid;
   logic [DATA_W-1:0] m_rdata;
   logic [1:0]        m_rresp;
   logic              beat_accept, beat_last, burst_active;
   logic [CNT_W-1:0]  bursts_done;

   int checks = 0;
   int errors = 0;

   // Model: in-flight beats in order (capacity 2), burst lock and completed-burst count.
   r_beat_t          q[$];
   bit               mdl_burst;
   logic [2:0]       mdl_lock;
   logic [CNT_W-1:0] mdl_cnt;

   always #5 clk = ~clk;

   r_resp_mux_skid dut (
      .clk (clk), .reset (reset), .R_slv_sel (r_slv_sel), .hold (hold),
      .s0_RVALID (s_rvalid[0]), .s0_RID (s_rid[0]), .s0_RDATA (s_rdata[0]), .s0_RRESP (s_rresp[0]), .s0_RLAST (s_rlast[0]), .s0_RREADY (s_rready[0]),
      .s1_RVALID (s_rvalid[1]), .s1_RID (s_rid[1]), .s1_RDATA (s_rdata[1]), .s1_RRESP (s_rresp[1]), .s1_RLAST (s_rlast[1]), .s1_RREADY (s_rready[1]),
      .s2_RVALID (s_rvalid[2]), .s2_RID (s_rid[2]), .s2_RDATA (s_rdata[2]), .s2_RRESP (s_rresp[2]), .s2_RLAST (s_rlast[2]), .s2_RREADY (s_rready[2]),
      .s3_RVALID (s_rvalid[3]), .s3_RID (s_rid[3]), .s3_RDATA (s_rdata[3]), .s3_RRESP (s_rresp[3]), .s3_RLAST (s_rlast[3]), .s3_RREADY (s_rready[3]),
      .s4_RVALID (s_rvalid[4]), .s4_RID (s_rid[4]), .s4_RDATA (s_rdata[4]), .s4_RRESP (s_rresp[4]), .s4_RLAST (s_rlast[4]), .s4_RREADY (s_rready[4]),
      .m_RVALID (m_rvalid), .m_RID (m_rid), .m_RDATA (m_rdata), .m_RRESP (m_rresp), .m_RLAST (m_rlast), .m_RREADY (m_rready),
      .beat_accept (beat_accept), .beat_last (beat_last), .burst_active (burst_active), .bursts_done (bursts_done)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Check one cycle against the model, then advance the model across the next rising edge.
   task automatic step();
      logic [2:0] sel_eff;
      bit         allow, exp_acc, fire;
      logic [4:0] exp_rdy;
      r_beat_t    b;
      #1;
      sel_eff = mdl_burst ? mdl_lock : r_slv_sel;
      allow   = mdl_burst || !hold;
      exp_rdy = '0;
      for (int n = 0; n < 5; n++)
         exp_rdy[n] = !reset && allow && (q.size() < 2) && (sel_eff == 3'(n));
      exp_acc = !reset && (q.size() > 0) && m_rready;
      chk("rready", 64'(s_rready), 64'(exp_rdy));
      chk("m_rvalid", 64'(m_rvalid), 64'(q.size() > 0));
      if (q.size() > 0) begin
         chk("m_rid", 64'(m_rid), 64'(q[0].id));
         chk("m_rdata", 64'(m_rdata), 64'(q[0].data));
         chk("m_rresp", 64'(m_rresp), 64'(q[0].resp));
         chk("m_rlast", 64'(m_rlast), 64'(q[0].last));
         chk("beat_last", 64'(beat_last), 64'(exp_acc && q[0].last));
      end else begin
         chk("beat_last", 64'(beat_last), 64'(0));
      end
      chk("beat_accept", 64'(beat_accept), 64'(exp_acc));
      chk("bursts_done", 64'(bursts_done), 64'(mdl_cnt));
      chk("burst_active", 64'(burst_active), 64'(mdl_burst));

      if (reset) begin
         q.delete();
         mdl_burst = 0;
         mdl_cnt   = '0;
      end else begin
         fire = 0;
         b    = '0;
         if (sel_eff < 3'd5) begin
            if (exp_rdy[sel_eff] && s_rvalid[sel_eff]) begin
               fire = 1;
               b = '{id: s_rid[sel_eff], data: s_rdata[sel_eff], resp: s_rresp[sel_eff], last: s_rlast[sel_eff]};
            end
         end
         if (exp_acc) begin
            if (q[0].last) mdl_cnt = mdl_cnt + CNT_W'(1);
            void'(q.pop_front());
         end
         if (fire) begin
            q.push_back(b);
            if (!mdl_burst && !b.last) begin
               mdl_burst = 1;
               mdl_lock  = r_slv_sel;
            end else if (mdl_burst && b.last) begin
               mdl_burst = 0;
            end
         end
      end
      @(posedge clk);
   endtask

   task automatic rand_inputs(input int vpct, input int rpct, input int hpct, input int lpct, input bit none_ok);
      for (int n = 0; n < 5; n++) begin
         s_rvalid[n] = ($urandom_range(0, 99) < vpct);
         s_rid[n]    = SID_W'($urandom);
         s_rdata[n]  = $urandom;
         s_rresp[n]  = 2'($urandom);
         s_rlast[n]  = ($urandom_range(0, 99) < lpct);
      end
      if ($urandom_range(0, 99) < 30)
         r_slv_sel = none_ok ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 4));
      hold     = ($urandom_range(0, 99) < hpct);
      m_rready = ($urandom_range(0, 99) < rpct);
   endtask

   initial begin
      reset = 1'b1; r_slv_sel = 3'd7; hold = 1'b0; m_rready = 1'b0;
      s_rvalid = '0; s_rlast = '0;
      for (int n = 0; n < 5; n++) begin
         s_rid[n] = '0; s_rdata[n] = '0; s_rresp[n] = '0;
      end
      mdl_burst = 0; mdl_lock = '0; mdl_cnt = '0;

      repeat (2) begin
         @(negedge clk);
         step();
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_m_rid", 64'(m_rid), 64'(0));
      chk("rst_m_rdata", 64'(m_rdata), 64'(0));
      chk("rst_m_rresp", 64'(m_rresp), 64'(0));
      chk("rst_m_rlast", 64'(m_rlast), 64'(0));

      // Directed single-beat read from slave 2.
      r_slv_sel = 3'd2; m_rready = 1'b1;
      s_rvalid[2] = 1'b1; s_rid[2] = 6'h05; s_rdata[2] = 32'hDEADBEEF; s_rlast[2] = 1'b1;
      step();
      @(negedge clk);
      s_rvalid = '0;
      step();
      @(negedge clk);
      step();

      // Directed: select in the none range with every slave valid.
      @(negedge clk);
      r_slv_sel = 3'd6; s_rvalid = '1;
      repeat (3) step();

      // Random phases: free flow, heavy backpressure, hold/none mix, random resets.
      for (int ph = 0; ph < 4; ph++) begin
         for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            case (ph)
               0: rand_inputs(70, 95, 10, 30, 0);
               1: rand_inputs(80, 20, 20, 25, 0);
               2: rand_inputs(60, 60, 50, 30, 1);
               default: rand_inputs(70, 50, 20, 25, 1);
            endcase
            reset = (ph == 3) && ($urandom_range(0, 99) < 3);
            step();
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
